// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
//   Shared types and helpers for the serial framer.
//   - state_t   : framer FSM states (IDLE, SHIFT, GAP)
//   - PAR_*     : parity mode encodings for the PARITY parameter
//   - frame_len : number of serial bits per frame (data bits + optional parity)
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int frame_len(input int data_w, input int parity);
    return data_w + ((parity != PAR_NONE) ? 1 : 0);
  endfunction

endpackage

// File: rtl/serial_frame_tx_parity.sv
// ser_parity_gen
//   Combinational parity over a data word.
//   Ports:
//     data : word to protect
//     odd  : 0 = even parity (bit makes total ones even), 1 = odd parity
//     par  : parity bit
module ser_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd,
  output logic              par
);

  assign par = (^data) ^ odd;

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Parallel-in / serial-out framer. Accepts one DATA_W-bit word per
//   valid/ready handshake and emits it one bit per clock on ser_out, with an
//   optional trailing parity bit and optional idle gap cycles between frames.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     s_data     : word to transmit, sampled only on the accept edge
//     s_valid    : s_data valid
//     s_ready    : framer can accept a word this cycle (combinational)
//     flush      : synchronous abort, drops the frame in flight
//     ser_out    : serial bit (IDLE_LVL when not shifting)
//     ser_valid  : ser_out carries a frame bit
//     ser_sof    : first bit of a frame
//     busy       : FSM is not in IDLE
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter int   LSB_FIRST  = 1,
  parameter int   PARITY     = 0,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LVL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              flush,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_sof,
  output logic              busy
);

  localparam int F     = frame_len(DATA_W, PARITY);
  localparam int CNT_W = $clog2(F + 1);
  localparam int GAP_W = 4;

  state_t           state, state_nx;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
  logic [F-1:0]     shreg;
  logic [DATA_W-1:0] data_ord;
  logic [F-1:0]     frame_word;
  logic             par_bit;
  logic             accept, last_bit, load, shift;
  logic             out_nx, valid_nx, sof_nx;

  ser_parity_gen #(.DATA_W(DATA_W)) u_par (
    .data (s_data),
    .odd  (PARITY == PAR_ODD),
    .par  (par_bit)
  );

  // Reorder the word so that bit 0 of frame_word is always the first bit on
  // the line; the shifter then only ever moves right.
  for (genvar g = 0; g < DATA_W; g++) begin : g_ord
    assign data_ord[g] = (LSB_FIRST != 0) ? s_data[g] : s_data[DATA_W-1-g];
  end

  if (PARITY != PAR_NONE) begin : g_par
    assign frame_word = {par_bit, data_ord};
  end else begin : g_nopar
    assign frame_word = data_ord;
  end

  // bit_cnt counts bits already placed on ser_out, so F means the last bit
  // is on the line this cycle.
  assign last_bit = (state == SHIFT) && (bit_cnt == CNT_W'(F));
  assign s_ready  = !flush && ((state == IDLE) || (last_bit && (GAP_CYCLES == 0)));
  assign accept   = s_valid && s_ready;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    load       = 1'b0;
    shift      = 1'b0;
    out_nx     = IDLE_LVL;
    valid_nx   = 1'b0;
    sof_nx     = 1'b0;
    if (flush) begin
      state_nx   = IDLE;
      bit_cnt_nx = '0;
      gap_cnt_nx = '0;
    end else if (accept) begin
      // Covers both IDLE and the back-to-back reload on the last bit.
      state_nx   = SHIFT;
      bit_cnt_nx = CNT_W'(1);
      load       = 1'b1;
      out_nx     = frame_word[0];
      valid_nx   = 1'b1;
      sof_nx     = 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (!last_bit) begin
            bit_cnt_nx = bit_cnt + CNT_W'(1);
            shift      = 1'b1;
            out_nx     = shreg[0];
            valid_nx   = 1'b1;
          end else begin
            bit_cnt_nx = '0;
            if (GAP_CYCLES > 0) begin
              state_nx   = GAP;
              gap_cnt_nx = GAP_W'(1);
            end else begin
              state_nx = IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES)) begin
            state_nx   = IDLE;
            gap_cnt_nx = '0;
          end else begin
            gap_cnt_nx = gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_out   <= IDLE_LVL;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      ser_out   <= out_nx;
      ser_valid <= valid_nx;
      ser_sof   <= sof_nx;
      busy      <= (state_nx != IDLE);
    end
  end

  // Remaining frame bits; bit 0 goes out next. Only read while in SHIFT.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= frame_word >> 1;
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  // Instance 0: LSB first, no parity, no gap
  // Instance 1: MSB first, even parity, 3 gap cycles
  // Instance 2: MSB first, odd parity, no gap
  localparam int LSB_T [3] = '{1, 0, 0};
  localparam int PAR_T [3] = '{0, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data [3];
  logic [2:0] s_valid, flush, s_ready, ser_out, ser_valid, ser_sof, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .LSB_FIRST(1), .PARITY(0), .GAP_CYCLES(0), .IDLE_LVL(1'b0)) u0 (
    .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .flush(flush[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .ser_sof(ser_sof[0]),
    .busy(busy[0]));

  serial_frame_tx #(.DATA_W(8), .LSB_FIRST(0), .PARITY(1), .GAP_CYCLES(3), .IDLE_LVL(1'b0)) u1 (
    .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .flush(flush[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .ser_sof(ser_sof[1]),
    .busy(busy[1]));

  serial_frame_tx #(.DATA_W(8), .LSB_FIRST(0), .PARITY(2), .GAP_CYCLES(0), .IDLE_LVL(1'b0)) u2 (
    .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .flush(flush[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]), .ser_sof(ser_sof[2]),
    .busy(busy[2]));

  // Reference: k-th bit on the line for word w on instance i.
  function automatic logic exp_bit(input logic [7:0] w, input int i, input int k);
    int ones = 0;
    int pos;
    if (k < 8) begin
      pos = (LSB_T[i] != 0) ? k : 7 - k;
      return ((w >> pos) & 8'd1) != 8'd0;
    end
    for (int b = 0; b < 8; b++) if (((w >> b) & 8'd1) != 8'd0) ones++;
    // even: bit makes total ones even; odd: makes total ones odd
    return (PAR_T[i] == 1) ? ((ones % 2) != 0) : ((ones % 2) == 0);
  endfunction

  function automatic int flen(input int i);
    return (PAR_T[i] != 0) ? 9 : 8;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present w, wait (bounded) for s_ready, pass the accept edge, then drop s_valid
  // and scramble s_data so later changes would show up if sampled.
  task automatic accept_word(input int i, input logic [7:0] w, output bit ok);
    int n = 0;
    s_data[i] = w;
    s_valid[i] = 1'b1;
    #1;
    while (s_ready[i] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    ok = (s_ready[i] === 1'b1);
    step();
    s_valid[i] = 1'b0;
    s_data[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    bit ok;
    int bad = 0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ser_valid[i] !== 1'b0 || ser_out[i] !== 1'b0 || ser_sof[i] !== 1'b0 ||
          busy[i] !== 1'b0 || s_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state inst%0d: valid=%b out=%b sof=%b busy=%b ready=%b, want 0 0 0 0 1",
                 i, ser_valid[i], ser_out[i], ser_sof[i], busy[i], s_ready[i]);
      end
    end
    rst = 1'b0;
    step();
    accept_word(0, 8'hC3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_accept: s_ready=0, want 1"); end
    step();
    step();
    checks++;
    if (busy[0] !== 1'b1 || ser_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe_active: busy=%b valid=%b, want 1 1", busy[0], ser_valid[0]);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (ser_valid[0] !== 1'b0 || ser_out[0] !== 1'b0 || s_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b out=%b ready=%b busy=%b, want 0 0 1 0",
               ser_valid[0], ser_out[0], s_ready[0], busy[0]);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (ser_valid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_spurious: %0d active cycles after reset, want 0", bad);
    end
  endtask

  task automatic test_lsb_first();
    bit ok;
    logic exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    accept_word(0, 8'hA5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lsb_accept: s_ready=0, want 1"); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ser_valid[0] !== 1'b1 || ser_out[0] !== exp[k] || ser_sof[0] !== (k == 0)) begin
        errors++;
        $display("FAIL lsb_bit%0d: valid=%b out=%b sof=%b, want 1 %b %b",
                 k, ser_valid[0], ser_out[0], ser_sof[0], exp[k], (k == 0));
      end
      if (k < 7) step();
    end
    step();
    checks++;
    if (ser_valid[0] !== 1'b0 || ser_out[0] !== 1'b0 || s_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL lsb_end: valid=%b out=%b ready=%b, want 0 0 1", ser_valid[0], ser_out[0], s_ready[0]);
    end
  endtask

  task automatic test_parity();
    bit ok;
    logic exp [9];
    for (int i = 1; i < 3; i++) begin
      exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, (i == 2)};
      accept_word(i, 8'hA5, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL parity_accept inst%0d: s_ready=0, want 1", i); end
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (ser_valid[i] !== 1'b1 || ser_out[i] !== exp[k] || ser_sof[i] !== (k == 0)) begin
          errors++;
          $display("FAIL parity inst%0d bit%0d: valid=%b out=%b sof=%b, want 1 %b %b",
                   i, k, ser_valid[i], ser_out[i], ser_sof[i], exp[k], (k == 0));
        end
        if (k < 8) step();
      end
      step();
      checks++;
      if (ser_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL parity_end inst%0d: valid=%b, want 0", i, ser_valid[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] w [2] = '{8'hFF, 8'h00};
    accept_word(0, w[0], ok);
    s_valid[0] = 1'b1;
    s_data[0] = w[1];
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_accept: s_ready=0, want 1"); end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (ser_valid[0] !== 1'b1 || ser_out[0] !== exp_bit(w[f], 0, k) || ser_sof[0] !== (k == 0) ||
            s_ready[0] !== (k == 7)) begin
          errors++;
          $display("FAIL b2b frame%0d bit%0d: valid=%b out=%b sof=%b ready=%b, want 1 %b %b %b",
                   f, k, ser_valid[0], ser_out[0], ser_sof[0], s_ready[0],
                   exp_bit(w[f], 0, k), (k == 0), (k == 7));
        end
        step();
        if (f == 1 || k == 7) s_valid[0] = 1'b0;
      end
    end
    checks++;
    if (ser_valid[0] !== 1'b0 || s_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: valid=%b ready=%b busy=%b, want 0 1 0", ser_valid[0], s_ready[0], busy[0]);
    end
  endtask

  task automatic test_gap();
    bit ok;
    int gapc = 0, idlec = 0, badgap = 0, n = 0;
    logic [7:0] w [2];
    w[0] = 8'($urandom);
    w[1] = 8'($urandom);
    accept_word(1, w[0], ok);
    s_valid[1] = 1'b1;
    s_data[1] = w[1];
    checks++;
    if (!ok) begin errors++; $display("FAIL gap_accept: s_ready=0, want 1"); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ser_valid[1] !== 1'b1 || ser_out[1] !== exp_bit(w[0], 1, k) || s_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL gap frame0 bit%0d: valid=%b out=%b ready=%b, want 1 %b 0",
                 k, ser_valid[1], ser_out[1], s_ready[1], exp_bit(w[0], 1, k));
      end
      step();
    end
    while (ser_valid[1] !== 1'b1 && n < 20) begin
      if (busy[1] === 1'b1) begin
        gapc++;
        if (ser_out[1] !== 1'b0 || s_ready[1] !== 1'b0) badgap++;
      end else begin
        idlec++;
      end
      step();
      n++;
    end
    s_valid[1] = 1'b0;
    checks++;
    if (gapc != 3 || badgap != 0) begin
      errors++;
      $display("FAIL gap_cycles: gap=%0d bad=%0d, want 3 0", gapc, badgap);
    end
    checks++;
    if (idlec != 1) begin
      errors++;
      $display("FAIL gap_idle: idle cycles=%0d, want 1", idlec);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ser_valid[1] !== 1'b1 || ser_out[1] !== exp_bit(w[1], 1, k) || ser_sof[1] !== (k == 0)) begin
        errors++;
        $display("FAIL gap frame1 bit%0d: valid=%b out=%b sof=%b, want 1 %b %b",
                 k, ser_valid[1], ser_out[1], ser_sof[1], exp_bit(w[1], 1, k), (k == 0));
      end
      step();
    end
  endtask

  task automatic test_flush();
    bit ok;
    accept_word(0, 8'h3C, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_accept: s_ready=0, want 1"); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ser_valid[0] !== 1'b1 || ser_out[0] !== exp_bit(8'h3C, 0, k)) begin
        errors++;
        $display("FAIL flush_pre bit%0d: valid=%b out=%b, want 1 %b",
                 k, ser_valid[0], ser_out[0], exp_bit(8'h3C, 0, k));
      end
      if (k < 3) step();
    end
    flush[0] = 1'b1;
    s_valid[0] = 1'b1;
    s_data[0] = 8'h81;
    #1;
    checks++;
    if (s_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: s_ready=%b during flush, want 0", s_ready[0]);
    end
    step();
    flush[0] = 1'b0;
    checks++;
    if (ser_valid[0] !== 1'b0 || ser_out[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: valid=%b out=%b busy=%b, want 0 0 0", ser_valid[0], ser_out[0], busy[0]);
    end
    step();
    s_valid[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ser_valid[0] !== 1'b1 || ser_out[0] !== exp_bit(8'h81, 0, k) || ser_sof[0] !== (k == 0)) begin
        errors++;
        $display("FAIL flush_next bit%0d: valid=%b out=%b sof=%b, want 1 %b %b",
                 k, ser_valid[0], ser_out[0], ser_sof[0], exp_bit(8'h81, 0, k), (k == 0));
      end
      step();
    end
  endtask

  task automatic test_random();
    bit ok;
    int i;
    logic [7:0] w;
    for (int r = 0; r < 24; r++) begin
      i = int'($urandom_range(0, 2));
      w = 8'($urandom);
      accept_word(i, w, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rand_accept r%0d inst%0d: s_ready=0, want 1", r, i); end
      for (int k = 0; k < flen(i); k++) begin
        checks++;
        if (ser_valid[i] !== 1'b1 || ser_out[i] !== exp_bit(w, i, k) || ser_sof[i] !== (k == 0)) begin
          errors++;
          $display("FAIL rand r%0d inst%0d w=%h bit%0d: valid=%b out=%b sof=%b, want 1 %b %b",
                   r, i, w, k, ser_valid[i], ser_out[i], ser_sof[i], exp_bit(w, i, k), (k == 0));
        end
        step();
      end
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_valid = '0;
    flush = '0;
    for (int i = 0; i < 3; i++) s_data[i] = '0;
    test_reset();
    test_lsb_first();
    test_parity();
    test_back_to_back();
    test_gap();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
